min_dist_scanner: RTL and testbench
===================================

# min_dist_scanner

Sequential arg-min unit for the Dijkstra datapath. On a start pulse it walks every node index, one per cycle, reading that node's tentative distance from the distance store. It returns the unvisited node with the smallest finite distance, which the controller uses as the next node to settle. It sits directly downstream of the distance store and drives that store's index port during a scan.

## Interface
- MAX_NODES, `DEFAULT_MAX_NODES, number of nodes scanned (any value ≥1, power of two not required)
- INDEX_WIDTH, `DEFAULT_INDEX_WIDTH, node index width; must satisfy 2^INDEX_WIDTH ≥ MAX_NODES
- VALUE_WIDTH, `DEFAULT_VALUE_WIDTH, distance width; `INFINITY marks unreachable

Ports:
- clock  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-low reset
- start  in  1  begin a scan; sampled only in IDLE
- visited  in  MAX_NODES  bit i=1 marks node i as settled; captured on the accepted start edge
- dist_index  out  INDEX_WIDTH  node index presented to the distance store
- dist_value  in  VALUE_WIDTH  store read data for dist_index, combinational, valid the same cycle
- busy  out  1  high from the accepted start through the DONE cycle
- done  out  1  one-cycle pulse; min_* outputs valid and stable from this cycle on
- found  out  1  an unvisited node with distance < `INFINITY exists
- min_index  out  INDEX_WIDTH  selected node
- min_value  out  VALUE_WIDTH  distance of the selected node

## Operation
- FSM states: IDLE, SCAN, DONE.
- IDLE, with start=1:
  - latch visited into visited_q
  - set counter idx=0, best_index=0, best_value=`INFINITY, best_found=0
  - go to SCAN
- SCAN:
  - dist_index = idx.
  - If visited_q[idx]=0 and dist_value < best_value (unsigned, strict), load best_index=idx, best_value=dist_value, best_found=1.
  - When idx==MAX_NODES-1, go to DONE. Otherwise idx+1.
  - The counter never wraps and never exceeds MAX_NODES-1.
- DONE: go to IDLE. In the same edge, load min_index/min_value/found from best_*.
- Tie-break: the lowest index wins, because of the strict comparison.
- Nodes at `INFINITY are never selected. If no node qualifies: found=0, min_index=0, min_value=`INFINITY.
- Read-only. The store's set_en is owned by the relaxation logic and must be held low by the controller while busy=1.
- start while busy=1 (SCAN or DONE) is ignored; it is not queued.
- The visited input is ignored after capture; changes mid-scan have no effect.
- min_*/found hold their values until the next DONE.
- dist_index = 0 in IDLE and DONE.

## Timing
- Reset (reset=0, asynchronous) clears everything:
  - state=IDLE, idx=0
  - busy=0, done=0, found=0
  - min_index=0, min_value=0, dist_index=0
- Reset asserted mid-scan aborts immediately: no done pulse, min_* return to reset values.
- Let E0 be the edge where start is accepted.
  - busy=1 after E0.
  - SCAN occupies the N=MAX_NODES cycles following E0; node k is read in cycle k+1.
  - The edge ending the last SCAN cycle enters DONE; done=1 and min_* are updated from that edge.
  - The next edge returns to IDLE; busy=0 and done=0.
- Start-to-done latency is MAX_NODES+1 cycles. busy spans exactly MAX_NODES+1 cycles.
- Back-to-back: a new start is accepted in the first IDLE cycle after DONE. Scan period is MAX_NODES+2 cycles.
- done and busy are registered outputs. dist_index is registered (it is the counter).

## Test plan
- MAX_NODES=4; dist={0,INF,INF,INF}; visited=0000; pulse start -> done exactly 5 cycles after the start edge, found=1, min_index=0, min_value=0; busy high for 5 cycles; dist_index sequence 0,1,2,3.
- dist={0,7,3,3}; visited=0001 -> found=1, min_index=2, min_value=3 (tie goes to index 2, not 3).
- dist={INF,INF-1,INF,5}; visited=1000 -> min_index=1, min_value=INF-1. Then visited=1111 -> found=0, min_index=0, min_value=INF.
- During a scan with dist={9,2,4,1} and visited=0000 captured: pulse start again and flip visited to 1111 mid-scan -> exactly one done, min_index=3, min_value=1; outputs hold through 10 idle cycles.
- Assert reset in the 2nd SCAN cycle -> busy=0, done=0, and outputs at reset values before the next edge. Release reset, then start with dist={5,6,7,8}, visited=0000 -> normal completion, min_index=0, min_value=5.
- Parameter sweep MAX_NODES=1 and MAX_NODES=5 (non-power-of-two) with random dist/visited vs a reference model. Check latency MAX_NODES+1, that dist_index never exceeds MAX_NODES-1, and that results match the model.

Source files
------------

// File: rtl/min_dist_scanner.sv
// Sequential arg-min over the distance store: walks every node index once
// and returns the unvisited node with the smallest finite distance.
`ifndef DEFAULT_MAX_NODES
`define DEFAULT_MAX_NODES 4
`endif
`ifndef DEFAULT_INDEX_WIDTH
`define DEFAULT_INDEX_WIDTH 2
`endif
`ifndef DEFAULT_VALUE_WIDTH
`define DEFAULT_VALUE_WIDTH 8
`endif
`ifndef INFINITY
`define INFINITY '1
`endif

module min_dist_scanner #(
  parameter int MAX_NODES   = `DEFAULT_MAX_NODES,
  parameter int INDEX_WIDTH = `DEFAULT_INDEX_WIDTH,
  parameter int VALUE_WIDTH = `DEFAULT_VALUE_WIDTH
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   start,
  input  logic [MAX_NODES-1:0]   visited,
  output logic [INDEX_WIDTH-1:0] dist_index,
  input  logic [VALUE_WIDTH-1:0] dist_value,
  output logic                   busy,
  output logic                   done,
  output logic                   found,
  output logic [INDEX_WIDTH-1:0] min_index,
  output logic [VALUE_WIDTH-1:0] min_value
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_SCAN = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [VALUE_WIDTH-1:0] INF = `INFINITY;
  localparam logic [INDEX_WIDTH-1:0] LAST =
    INDEX_WIDTH'(MAX_NODES - 1);

  logic [1:0]             state_q, state_d;
  logic [INDEX_WIDTH-1:0] idx_q, idx_d;
  logic [MAX_NODES-1:0]   visited_q, visited_d;
  logic [INDEX_WIDTH-1:0] best_index_q, best_index_d;
  logic [VALUE_WIDTH-1:0] best_value_q, best_value_d;
  logic                   best_found_q, best_found_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic                   found_q, found_d;
  logic [INDEX_WIDTH-1:0] min_index_q, min_index_d;
  logic [VALUE_WIDTH-1:0] min_value_q, min_value_d;

  logic                   cur_visited;
  logic                   take;
  logic [INDEX_WIDTH-1:0] scan_index;
  logic [VALUE_WIDTH-1:0] scan_value;
  logic                   scan_found;

  // Explicit compare loop keeps the index in range for non-power-of-two sizes
  always_comb begin
    cur_visited = 1'b0;
    for (int i = 0; i < MAX_NODES; i++) begin
      if (idx_q == INDEX_WIDTH'(i)) cur_visited = visited_q[i];
    end
  end

  // Strict compare: ties keep the lower index, INF never beats INF
  always_comb begin
    take       = !cur_visited && (dist_value < best_value_q);
    scan_index = take ? idx_q : best_index_q;
    scan_value = take ? dist_value : best_value_q;
    scan_found = best_found_q | take;
  end

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    visited_d    = visited_q;
    best_index_d = best_index_q;
    best_value_d = best_value_q;
    best_found_d = best_found_q;
    busy_d       = busy_q;
    done_d       = 1'b0;
    found_d      = found_q;
    min_index_d  = min_index_q;
    min_value_d  = min_value_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d      = S_SCAN;
          visited_d    = visited;
          idx_d        = '0;
          best_index_d = '0;
          best_value_d = INF;
          best_found_d = 1'b0;
          busy_d       = 1'b1;
        end
      end
      S_SCAN: begin
        best_index_d = scan_index;
        best_value_d = scan_value;
        best_found_d = scan_found;
        if (idx_q == LAST) begin
          state_d     = S_DONE;
          idx_d       = '0;
          done_d      = 1'b1;
          found_d     = scan_found;
          min_index_d = scan_index;
          min_value_d = scan_value;
        end else begin
          idx_d = idx_q + INDEX_WIDTH'(1);
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = S_IDLE;
        idx_d   = '0;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      idx_q        <= '0;
      visited_q    <= '0;
      best_index_q <= '0;
      best_value_q <= '0;
      best_found_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      found_q      <= 1'b0;
      min_index_q  <= '0;
      min_value_q  <= '0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      visited_q    <= visited_d;
      best_index_q <= best_index_d;
      best_value_q <= best_value_d;
      best_found_q <= best_found_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      found_q      <= found_d;
      min_index_q  <= min_index_d;
      min_value_q  <= min_value_d;
    end
  end

  assign dist_index = idx_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign found      = found_q;
  assign min_index  = min_index_q;
  assign min_value  = min_value_q;

endmodule

// File: tb/tb_min_dist_scanner.sv
// Bench for min_dist_scanner: three sizes (4, 1, 5 nodes) against an
// arg-min reference model over the bench's own distance store.
module tb_min_dist_scanner;

  localparam int INF = 255;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start_v [3];
  logic [7:0] vis_v [3];
  logic [7:0] dist_m [3][8];

  logic       busy_o [3];
  logic       done_o [3];
  logic       found_o [3];
  logic [2:0] idx_o [3];
  logic [2:0] mi_o [3];
  logic [7:0] mv_o [3];

  logic [1:0] di4, mi4;
  logic [0:0] di1, mi1;
  logic [2:0] di5, mi5;
  logic [7:0] dv4, dv1, dv5;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  assign dv4 = dist_m[0][{1'b0, di4}];
  assign dv1 = dist_m[1][{2'b00, di1}];
  assign dv5 = dist_m[2][di5];

  assign idx_o[0] = {1'b0, di4};
  assign idx_o[1] = {2'b00, di1};
  assign idx_o[2] = di5;
  assign mi_o[0]  = {1'b0, mi4};
  assign mi_o[1]  = {2'b00, mi1};
  assign mi_o[2]  = mi5;

  min_dist_scanner #(
    .MAX_NODES(4), .INDEX_WIDTH(2), .VALUE_WIDTH(8)
  ) u_n4 (
    .clock(clk), .reset(rst_n), .start(start_v[0]),
    .visited(vis_v[0][3:0]), .dist_index(di4),
    .dist_value(dv4), .busy(busy_o[0]), .done(done_o[0]),
    .found(found_o[0]), .min_index(mi4), .min_value(mv_o[0])
  );

  min_dist_scanner #(
    .MAX_NODES(1), .INDEX_WIDTH(1), .VALUE_WIDTH(8)
  ) u_n1 (
    .clock(clk), .reset(rst_n), .start(start_v[1]),
    .visited(vis_v[1][0:0]), .dist_index(di1),
    .dist_value(dv1), .busy(busy_o[1]), .done(done_o[1]),
    .found(found_o[1]), .min_index(mi1), .min_value(mv_o[1])
  );

  min_dist_scanner #(
    .MAX_NODES(5), .INDEX_WIDTH(3), .VALUE_WIDTH(8)
  ) u_n5 (
    .clock(clk), .reset(rst_n), .start(start_v[2]),
    .visited(vis_v[2][4:0]), .dist_index(di5),
    .dist_value(dv5), .busy(busy_o[2]), .done(done_o[2]),
    .found(found_o[2]), .min_index(mi5), .min_value(mv_o[2])
  );

  task automatic chk(input string tag, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int nn(input int u);
    return (u == 0) ? 4 : ((u == 1) ? 1 : 5);
  endfunction

  // Arg-min: smallest finite unvisited value, first index holding it
  function automatic void ref_min(input int u, input logic [7:0] vis,
                                  output int f, output int mi,
                                  output int mv);
    int vals[$];
    int m[$];
    int ix[$];
    for (int i = 0; i < nn(u); i++) begin
      if (!vis[i] && int'(dist_m[u][i]) != INF)
        vals.push_back(int'(dist_m[u][i]));
      else
        vals.push_back(INF + 1);
    end
    m  = vals.min();
    ix = vals.find_first_index(x) with (x == m[0]);
    if (m[0] > INF) begin
      f = 0; mi = 0; mv = INF;
    end else begin
      f = 1; mi = ix[0]; mv = m[0];
    end
  endfunction

  task automatic load4(input int a, input int b, input int c, input int d);
    dist_m[0][0] = 8'(a);
    dist_m[0][1] = 8'(b);
    dist_m[0][2] = 8'(c);
    dist_m[0][3] = 8'(d);
  endtask

  task automatic run_scan(input int u, input logic [7:0] vis,
                          input bit disturb, input int ef,
                          input int emi, input int emv);
    int n;
    n = nn(u);
    @(negedge clk);
    start_v[u] = 1'b1;
    vis_v[u]   = vis;
    @(posedge clk);
    #1;
    start_v[u] = 1'b0;
    vis_v[u]   = ~vis;
    for (int c = 1; c <= n + 3; c++) begin
      @(negedge clk);
      if (disturb && c == 2) begin
        start_v[u] = 1'b1;
        vis_v[u]   = 8'hff;
      end
      if (disturb && c == 3) start_v[u] = 1'b0;
      if (c <= n) begin
        chk($sformatf("u%0d busy c%0d", u, c), int'(busy_o[u]), 1);
        chk($sformatf("u%0d done_early c%0d", u, c), int'(done_o[u]), 0);
        chk($sformatf("u%0d dist_index c%0d", u, c), int'(idx_o[u]), c - 1);
      end else if (c == n + 1) begin
        chk($sformatf("u%0d done", u), int'(done_o[u]), 1);
        chk($sformatf("u%0d busy_last", u), int'(busy_o[u]), 1);
        chk($sformatf("u%0d dist_index_done", u), int'(idx_o[u]), 0);
      end else begin
        chk($sformatf("u%0d done_after c%0d", u, c), int'(done_o[u]), 0);
        chk($sformatf("u%0d busy_after c%0d", u, c), int'(busy_o[u]), 0);
        chk($sformatf("u%0d dist_index_idle c%0d", u, c), int'(idx_o[u]), 0);
      end
      if (c >= n + 1) begin
        chk($sformatf("u%0d found c%0d", u, c), int'(found_o[u]), ef);
        chk($sformatf("u%0d min_index c%0d", u, c), int'(mi_o[u]), emi);
        chk($sformatf("u%0d min_value c%0d", u, c), int'(mv_o[u]), emv);
      end
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, " busy"}, int'(busy_o[0]), 0);
    chk({tag, " done"}, int'(done_o[0]), 0);
    chk({tag, " found"}, int'(found_o[0]), 0);
    chk({tag, " min_index"}, int'(mi_o[0]), 0);
    chk({tag, " min_value"}, int'(mv_o[0]), 0);
    chk({tag, " dist_index"}, int'(idx_o[0]), 0);
  endtask

  initial begin
    int f, mi, mv;
    logic [7:0] vis;
    rst_n = 1'b0;
    for (int u = 0; u < 3; u++) begin
      start_v[u] = 1'b0;
      vis_v[u]   = '0;
      for (int i = 0; i < 8; i++) dist_m[u][i] = 8'(INF);
    end
    repeat (2) @(negedge clk);
    chk_reset_vals("por");
    rst_n = 1'b1;

    load4(0, INF, INF, INF);
    run_scan(0, 8'b0000, 1'b0, 1, 0, 0);

    load4(0, 7, 3, 3);
    run_scan(0, 8'b0001, 1'b0, 1, 2, 3);

    load4(INF, INF - 1, INF, 5);
    run_scan(0, 8'b1000, 1'b0, 1, 1, INF - 1);
    run_scan(0, 8'b1111, 1'b0, 0, 0, INF);

    load4(9, 2, 4, 1);
    run_scan(0, 8'b0000, 1'b1, 1, 3, 1);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk("hold done", int'(done_o[0]), 0);
      chk("hold found", int'(found_o[0]), 1);
      chk("hold min_index", int'(mi_o[0]), 3);
      chk("hold min_value", int'(mv_o[0]), 1);
    end

    // Abort in the second scan cycle
    load4(5, 6, 7, 8);
    @(negedge clk);
    start_v[0] = 1'b1;
    vis_v[0]   = '0;
    @(posedge clk);
    #1 start_v[0] = 1'b0;
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1 chk_reset_vals("abort");
    @(negedge clk);
    chk_reset_vals("abort_held");
    rst_n = 1'b1;
    run_scan(0, 8'b0000, 1'b0, 1, 0, 5);

    for (int u = 0; u < 3; u++) begin
      for (int t = 0; t < 20; t++) begin
        for (int i = 0; i < nn(u); i++)
          dist_m[u][i] = ($urandom_range(0, 3) == 0) ?
                         8'(INF) : 8'($urandom_range(0, 15));
        vis = 8'($urandom) & 8'(($urandom_range(0, 1) == 0) ? 0 : 255);
        ref_min(u, vis, f, mi, mv);
        run_scan(u, vis, 1'b0, f, mi, mv);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
